// File: rtl/uart_rx_linebuf.sv
// 16x-oversampling UART receiver feeding a character FIFO. Characters reach the consumer
// only once the whole line they belong to has been received.
module uart_rx_linebuf #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned LINE_LEN  = 80,
  parameter int unsigned DEPTH     = 160,
  parameter logic [7:0]  EOL       = 8'h0A
) (
  input  logic                       soc_clk,
  input  logic                       soc_aresetn,
  input  logic                       rx,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           clk_div,
  output logic [DATA_BITS-1:0]       m_data,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun,
  output logic [$clog2(DEPTH+1)-1:0] lines_pending
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LC_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned BI_W  = $clog2(DATA_BITS);

  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LC_W-1:0]      LC_LAST  = LC_W'(LINE_LEN - 1);
  localparam logic [BI_W-1:0]      BI_LAST  = BI_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] EOL_C    = DATA_BITS'(EOL);
  localparam logic                 ODD_PAR  = (PARITY == 1);
  localparam logic                 HAS_PAR  = (PARITY != 0);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StWaitHi = 3'd5;

  // Input synchroniser and oversample divider
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  // Frame FSM
  logic [2:0]           state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  logic                 sample;
  logic                 exp_par;
  logic                 commit;

  // Error pulses
  logic frame_err_q, frame_err_d;
  logic parity_err_q, parity_err_d;
  logic overrun_q, overrun_d;

  // Character FIFO and line accounting
  logic [DATA_BITS:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     lines_q, lines_d;
  logic [LC_W-1:0]      line_cnt_q, line_cnt_d;
  logic [DATA_BITS:0]   head;
  logic                 full;
  logic                 push;
  logic                 push_last;
  logic                 pop;
  logic                 line_inc;
  logic                 line_dec;

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    // >= so that lowering clk_div below the running count still wraps promptly
    tick      = (div_cnt_q >= clk_div);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    commit       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    sample       = tick && (tick_cnt_q == 4'd7);
    exp_par      = (^shreg_q) ^ ODD_PAR;

    if (tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end

    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_d    = StStart;
            tick_cnt_d = '0;
            par_bad_d  = 1'b0;
          end
        end
        StStart: begin
          if (sample) begin
            state_d   = rx_sync_q ? StIdle : StData;
            bit_idx_d = '0;
          end
        end
        StData: begin
          if (sample) begin
            shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == BI_LAST) begin
              state_d = HAS_PAR ? StParity : StStop;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (sample) begin
            par_bad_d = (rx_sync_q != exp_par);
            state_d   = StStop;
          end
        end
        StStop: begin
          if (sample) begin
            // A bad stop bit masks any parity error: one pulse per frame
            if (!rx_sync_q) begin
              frame_err_d = 1'b1;
              state_d     = StWaitHi;
            end else if (par_bad_q) begin
              parity_err_d = 1'b1;
              state_d      = StIdle;
            end else begin
              commit  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StWaitHi: begin
          if (rx_sync_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign m_valid = (lines_q != '0) && (cnt_q != '0);
  assign m_data  = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_last  = m_valid & head[DATA_BITS];

  always_comb begin
    pop       = m_valid & m_ready;
    full      = (cnt_q == CNT_FULL);
    push_last = (shreg_q == EOL_C) || (line_cnt_q == LC_LAST);
    // A same-cycle pop frees the slot, so a full FIFO can still accept the commit
    push      = commit & (~full | pop);
    overrun_d = commit & full & ~pop;
    line_inc  = push & push_last;
    line_dec  = pop & head[DATA_BITS];

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    lines_d    = lines_q;
    line_cnt_d = line_cnt_q;

    if (push) begin
      wr_ptr_d   = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      line_cnt_d = push_last ? '0 : line_cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (line_inc && !line_dec) begin
      lines_d = lines_q + 1'b1;
    end else if (line_dec && !line_inc) begin
      lines_d = lines_q - 1'b1;
    end
  end

  always_ff @(posedge soc_clk or negedge soc_aresetn) begin
    if (!soc_aresetn) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      div_cnt_q    <= '0;
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      lines_q      <= '0;
      line_cnt_q   <= '0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      lines_q      <= lines_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  // Storage is not reset; m_data/m_last are gated by m_valid instead
  always_ff @(posedge soc_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_last, shreg_q};
    end
  end

  assign frame_err     = frame_err_q;
  assign parity_err    = parity_err_q;
  assign overrun       = overrun_q;
  assign lines_pending = lines_q;

endmodule
